// File: rtl/ram_display_reader.sv
// ram_display_reader: scans the character RAM from address 0 and streams each entry to the UART over valid/ready.
// Optional build macro NUL_STOP_EN: end the dump early at the first 0x00 entry.
`default_nettype none

module ram_display_reader #(
  parameter int DEPTH      = 40,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  output logic [ADDR_WIDTH-1:0] address_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [DATA_WIDTH-1:0] char_q,  char_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      char_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      char_q  <= char_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    char_d  = char_q;
    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        char_d = ram_data_i;
`ifdef NUL_STOP_EN
        state_d = (ram_data_i == '0) ? S_DONE : S_SEND;
`else
        state_d = S_SEND;
`endif
      end
      S_SEND: begin
        // Character and address stay frozen until the transmitter takes the byte.
        if (tx_ready_i) begin
          if (addr_q == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        addr_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        addr_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign address_o  = addr_q;
  assign tx_data_o  = 8'(char_q);
  assign tx_valid_o = (state_q == S_SEND);
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_ram_display_reader.sv
// Bench for ram_display_reader: RAM model, transfer monitor and per-scenario scoreboard checks.
`timescale 1ns/1ps
`default_nettype none

module tb_ram_display_reader;

  localparam int DEPTH = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       tx_ready = 1'b0;
  logic [5:0] address;
  logic [6:0] ram_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic       done;

  logic [6:0] ram [0:DEPTH-1];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Written only by the monitor.
  int xfer_count = 0;
  int done_count = 0;
  int done_cyc = 0;
  int overlap_count = 0;
  logic [7:0] obs_q[$];
  logic [5:0] obs_addr_q[$];

  logic [7:0] exp_q[$];

  ram_display_reader #(.DEPTH(DEPTH), .ADDR_WIDTH(6), .DATA_WIDTH(7)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .address_o  (address),
    .ram_data_i (ram_data),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ram_data = (address < 6'(DEPTH)) ? ram[address] : 7'd0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid && tx_ready) begin
        obs_q.push_back(tx_data);
        obs_addr_q.push_back(address);
        xfer_count++;
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
      if (done && tx_valid) overlap_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ram_default();
    string s;
    byte   b;
    s = "ECE333 Fall 2015 Digital Systems\n\r";
    for (int i = 0; i < DEPTH; i++) begin
      if (i < s.len()) begin
        b = s[i];
        ram[i] = b[6:0];
      end else begin
        ram[i] = 7'h00;
      end
    end
  endtask

  // Expected stream for one dump of the current RAM contents.
  task automatic push_dump();
    for (int i = 0; i < DEPTH; i++) begin
`ifdef NUL_STOP_EN
      if (ram[i] == 7'h00) break;
`endif
      exp_q.push_back({1'b0, ram[i]});
    end
  endtask

  task automatic flush_obs();
    obs_q.delete();
    obs_addr_q.delete();
  endtask

  task automatic pulse_start(output int s_cyc);
    start = 1'b1;
    s_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_count != d0) break;
      tick();
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({address, tx_data, tx_valid, busy, done} !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_async: addr=%0d data=%h valid=%b busy=%b done=%b, required all 0",
               address, tx_data, tx_valid, busy, done);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if ({address, tx_data, tx_valid, busy, done} !== 17'd0) begin
        miscompares++;
        $display("FAIL reset_idle cycle %0d: addr=%0d data=%h valid=%b busy=%b done=%b, required all 0",
                 i, address, tx_data, tx_valid, busy, done);
      end
    end
  endtask

  task automatic test_full_dump();
    int s_cyc, d0, x0, n_exp, exp_lat, idx;
    logic [7:0] e, o;
    logic [5:0] a;
    load_ram_default();
    exp_q.delete();
    flush_obs();
    tx_ready = 1'b1;
    d0 = done_count;
    x0 = xfer_count;
    push_dump();
    n_exp = exp_q.size();
    exp_lat = (n_exp < DEPTH) ? 2 * n_exp + 2 : 2 * n_exp + 1;
    pulse_start(s_cyc);
    vectors++;
    if (busy !== 1'b1 || tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL full_fetch_cycle: busy=%b valid=%b, required busy=1 valid=0", busy, tx_valid);
    end
    tick();
    vectors++;
    if (tx_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL full_first_valid: valid=%b, required 1", tx_valid);
    end
    wait_done(d0, 200);
    vectors++;
    if (done_count - d0 != 1) begin
      miscompares++;
      $display("FAIL full_done_count: got %0d, required 1", done_count - d0);
    end
    vectors++;
    if (done_cyc - s_cyc != exp_lat) begin
      miscompares++;
      $display("FAIL full_done_latency: got %0d, required %0d", done_cyc - s_cyc, exp_lat);
    end
    vectors++;
    if (xfer_count - x0 != n_exp) begin
      miscompares++;
      $display("FAIL full_xfer_count: got %0d, required %0d", xfer_count - x0, n_exp);
    end
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL full_data[%0d]: no transfer, required %h", idx, e);
      end else begin
        o = obs_q.pop_front();
        a = obs_addr_q.pop_front();
        if (o !== e || a !== 6'(idx)) begin
          miscompares++;
          $display("FAIL full_data[%0d]: got %h at addr %0d, required %h at addr %0d", idx, o, a, e, idx);
        end
      end
      idx++;
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL full_extra: %0d extra transfers, required 0", obs_q.size());
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || address !== 6'd0) begin
      miscompares++;
      $display("FAIL full_back_idle: busy=%b addr=%0d, required 0/0", busy, address);
    end
    vectors++;
    if (overlap_count != 0) begin
      miscompares++;
      $display("FAIL done_valid_overlap: got %0d cycles, required 0", overlap_count);
    end
    flush_obs();
  endtask

  task automatic test_backpressure();
    int s_cyc, d0;
    bit found;
    logic [7:0] e, o;
    load_ram_default();
    exp_q.delete();
    flush_obs();
    tx_ready = 1'b1;
    d0 = done_count;
    push_dump();
    pulse_start(s_cyc);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (address == 6'd1 && tx_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL bp_reach_addr1: addr=%0d valid=%b, required addr 1 with valid", address, tx_valid);
    end
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h43 || address !== 6'd1) begin
        miscompares++;
        $display("FAIL bp_hold cycle %0d: valid=%b data=%h addr=%0d, required 1/43/1",
                 i, tx_valid, tx_data, address);
      end
    end
    tx_ready = 1'b1;
    wait_done(d0, 200);
    vectors++;
    if (obs_q.size() < 3) begin
      miscompares++;
      $display("FAIL bp_release: only %0d transfers, required at least 3", obs_q.size());
    end else if (obs_q[2] !== 8'h45 || obs_addr_q[2] !== 6'd2) begin
      miscompares++;
      $display("FAIL bp_release: got %h at addr %0d, required 45 at addr 2", obs_q[2], obs_addr_q[2]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL bp_data: no transfer, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL bp_data: got %h, required %h", o, e);
        end
      end
    end
    tick();
    flush_obs();
  endtask

  task automatic test_start_ignored();
    int d0, x0, n_exp;
    load_ram_default();
    exp_q.delete();
    flush_obs();
    tx_ready = 1'b1;
    d0 = done_count;
    x0 = xfer_count;
    push_dump();
    n_exp = exp_q.size();
    start = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (done_count != d0) break;
    end
    start = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    vectors++;
    if (done_count - d0 != 1) begin
      miscompares++;
      $display("FAIL start_ignored_done: got %0d pulses, required 1", done_count - d0);
    end
    vectors++;
    if (xfer_count - x0 != n_exp) begin
      miscompares++;
      $display("FAIL start_ignored_xfers: got %0d, required %0d", xfer_count - x0, n_exp);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_ignored_idle: busy=%b, required 0", busy);
    end
    exp_q.delete();
    flush_obs();
  endtask

  task automatic test_reset_mid();
    int s_cyc, d0, x0;
    load_ram_default();
    exp_q.delete();
    flush_obs();
    tx_ready = 1'b1;
    x0 = xfer_count;
    push_dump();
    pulse_start(s_cyc);
    for (int i = 0; i < 100; i++) begin
      if (xfer_count - x0 >= 10) break;
      tick();
    end
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || address !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: valid=%b busy=%b addr=%0d, required 0/0/0", tx_valid, busy, address);
    end
    d0 = done_count;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if (done_count != d0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_no_done: done pulses %0d busy=%b, required 0/0", done_count - d0, busy);
    end
    exp_q.delete();
    flush_obs();
    push_dump();
    pulse_start(s_cyc);
    for (int i = 0; i < 20; i++) begin
      if (obs_q.size() > 0) break;
      tick();
    end
    vectors++;
    if (obs_q.size() == 0) begin
      miscompares++;
      $display("FAIL reset_mid_restart: no transfer, required 45 at addr 0");
    end else if (obs_q[0] !== exp_q[0] || obs_addr_q[0] !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_mid_restart: got %h at addr %0d, required %h at addr 0",
               obs_q[0], obs_addr_q[0], exp_q[0]);
    end
    wait_done(d0, 200);
    tick();
    exp_q.delete();
    flush_obs();
  endtask

`ifdef NUL_STOP_EN
  task automatic test_empty();
    int s_cyc, d0, x0;
    load_ram_default();
    ram[0] = 7'h00;
    exp_q.delete();
    flush_obs();
    tx_ready = 1'b1;
    d0 = done_count;
    x0 = xfer_count;
    pulse_start(s_cyc);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL empty_busy1: busy=%b, required 1", busy);
    end
    tick();
    vectors++;
    if (busy !== 1'b1 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL empty_done: busy=%b done=%b, required 1/1", busy, done);
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || done_cyc - s_cyc != 2 || xfer_count != x0 || done_count - d0 != 1) begin
      miscompares++;
      $display("FAIL empty_end: busy=%b latency=%0d xfers=%0d dones=%0d, required 0/2/0/1",
               busy, done_cyc - s_cyc, xfer_count - x0, done_count - d0);
    end
  endtask
`endif

  initial begin
    load_ram_default();
    test_reset();
    test_full_dump();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
`ifdef NUL_STOP_EN
    test_empty();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
